// File: rtl/mem_write_checker.sv
// Self-check unit for the single-cycle MIPS computer: compares data-memory stores
// against a loadable table of expected (address, data) writes and reports the verdict.
module mem_write_checker #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int NCHK     = 4,
    parameter int PC_LIMIT = 100,
    parameter int TIMEOUT  = 1024,
    localparam int IW      = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    input  logic            start,
    input  logic            ordered,
    input  logic            strict,
    input  logic            memwrite,
    input  logic [AW-1:0]   dataadr,
    input  logic [DW-1:0]   writedata,
    input  logic [AW-1:0]   pc,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic [2:0]      fail_code,
    output logic [NCHK-1:0] match_mask,
    output logic [15:0]     cycle_count
);

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_STRAY   = 3'd1;
    localparam logic [2:0] FC_DATA    = 3'd2;
    localparam logic [2:0] FC_ORDER   = 3'd3;
    localparam logic [2:0] FC_PC      = 3'd4;
    localparam logic [2:0] FC_TIMEOUT = 3'd5;

    localparam logic [AW-1:0] PC_MAX = AW'(PC_LIMIT);
    localparam logic [31:0]   TMO    = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    function automatic logic [NCHK-1:0] lowest_set(input logic [NCHK-1:0] v);
        return v & (~v + NCHK'(1));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t          state;
    logic [AW-1:0]   exp_addr [NCHK];
    logic [DW-1:0]   exp_data [NCHK];
    logic [NCHK-1:0] valid;
    logic            ordered_run;
    logic            strict_run;

    logic [NCHK-1:0] cfg_sel;
    logic [NCHK-1:0] load_valid;
    logic [NCHK-1:0] addr_hit;
    logic [NCHK-1:0] full_hit;
    logic [NCHK-1:0] head_sel;
    logic [NCHK-1:0] hit_sel;
    logic [NCHK-1:0] mask_next;
    logic [2:0]      viol_code;
    logic [15:0]     cnt_next;

    always_comb begin
        cfg_sel  = '0;
        addr_hit = '0;
        full_hit = '0;
        for (int i = 0; i < NCHK; i++) begin
            cfg_sel[i]  = cfg_we && (cfg_idx == IW'(i));
            addr_hit[i] = valid[i] && (exp_addr[i] == dataadr);
            full_hit[i] = addr_hit[i] && (exp_data[i] == writedata);
        end
    end

    // Ordered mode only looks at the head: entries match in index order and invalid
    // ones start matched, so the lowest unmatched entry is the order pointer.
    always_comb begin
        head_sel  = lowest_set(~match_mask);
        hit_sel   = '0;
        viol_code = FC_NONE;
        if (memwrite) begin
            if (ordered_run) begin
                hit_sel = head_sel & full_hit;
                if ((hit_sel == '0) && strict_run)
                    viol_code = FC_ORDER;
            end else begin
                hit_sel = lowest_set(full_hit & ~match_mask);
                if ((hit_sel == '0) && strict_run) begin
                    if ((addr_hit & ~match_mask) != '0)
                        viol_code = FC_DATA;
                    else if (addr_hit == '0)
                        viol_code = FC_STRAY;
                end
            end
        end
    end

    assign mask_next  = match_mask | hit_sel;
    assign cnt_next   = sat_inc(cycle_count);
    assign load_valid = valid | cfg_sel;

    always_ff @(posedge clk) begin
        if (state != RUN) begin
            for (int i = 0; i < NCHK; i++) begin
                if (cfg_sel[i]) begin
                    exp_addr[i] <= cfg_addr;
                    exp_data[i] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            valid       <= '0;
            ordered_run <= 1'b0;
            strict_run  <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= FC_NONE;
            match_mask  <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    match_mask  <= mask_next;
                    cycle_count <= cnt_next;
                    if (&mask_next) begin
                        state <= PASS;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (viol_code != FC_NONE) begin
                        state     <= FAIL;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= viol_code;
                    end else if (pc > PC_MAX) begin
                        state     <= FAIL;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= FC_PC;
                    end else if ({16'd0, cnt_next} >= TMO) begin
                        state     <= FAIL;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                default: begin
                    valid <= load_valid;
                    // An entry written in the start cycle already counts for this run.
                    if (start) begin
                        state       <= RUN;
                        ordered_run <= ordered;
                        strict_run  <= strict;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        fail_code   <= FC_NONE;
                        match_mask  <= ~load_valid;
                        cycle_count <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus random traffic, all checked
// against a table-level reference model and against fixed expected verdicts.
module tb_mem_write_checker;

    localparam int NCHK      = 2;
    localparam int PC_LIMIT  = 100;
    localparam int TIMEOUT   = 1024;
    localparam int TIMEOUT_T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cfg_we, start, ordered, strict, memwrite;
    logic [0:0]  cfg_idx;
    logic [31:0] cfg_addr, cfg_data, dataadr, writedata, pc;

    logic            done, pass, fail;
    logic [2:0]      fail_code;
    logic [NCHK-1:0] match_mask;
    logic [15:0]     cycle_count;

    logic            done_t, pass_t, fail_t;
    logic [2:0]      fail_code_t;
    logic [NCHK-1:0] match_mask_t;
    logic [15:0]     cycle_count_t;

    mem_write_checker #(.DW(32), .AW(32), .NCHK(NCHK), .PC_LIMIT(PC_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .ordered(ordered), .strict(strict),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .pc(pc),
        .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_mask(match_mask), .cycle_count(cycle_count)
    );

    mem_write_checker #(.DW(32), .AW(32), .NCHK(NCHK), .PC_LIMIT(PC_LIMIT), .TIMEOUT(TIMEOUT_T)) dut_t (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .ordered(ordered), .strict(strict),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .pc(pc),
        .done(done_t), .pass(pass_t), .fail(fail_t), .fail_code(fail_code_t),
        .match_mask(match_mask_t), .cycle_count(cycle_count_t)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the default-TIMEOUT instance.
    logic [31:0] m_addr [NCHK];
    logic [31:0] m_data [NCHK];
    bit          m_valid [NCHK];
    bit          m_matched [NCHK];
    bit          m_run, m_done, m_pass, m_fail, m_ord, m_str;
    int          m_code, m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NCHK-1:0] m_maskv();
        logic [NCHK-1:0] v;
        for (int i = 0; i < NCHK; i++) v[i] = m_matched[i];
        return v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pass = 0; m_fail = 0; m_code = 0; m_cnt = 0;
        m_ord = 0; m_str = 0;
        for (int i = 0; i < NCHK; i++) begin
            m_valid[i] = 0;
            m_matched[i] = 0;
        end
    endtask

    task automatic model_edge();
        int  hit;
        int  code;
        int  p;
        bit  all_done;
        bit  any_addr;
        bit  any_unm_addr;
        hit = -1; code = 0; p = -1; any_addr = 0; any_unm_addr = 0;
        if (!m_run) begin
            if (cfg_we) begin
                m_addr[cfg_idx]  = cfg_addr;
                m_data[cfg_idx]  = cfg_data;
                m_valid[cfg_idx] = 1;
            end
            if (start) begin
                m_run = 1; m_done = 0; m_pass = 0; m_fail = 0; m_code = 0; m_cnt = 0;
                m_ord = ordered; m_str = strict;
                for (int i = 0; i < NCHK; i++) m_matched[i] = !m_valid[i];
            end
        end else begin
            if (memwrite) begin
                if (m_ord) begin
                    for (int i = NCHK - 1; i >= 0; i--) if (!m_matched[i]) p = i;
                    if (p >= 0 && m_addr[p] == dataadr && m_data[p] == writedata) hit = p;
                    else if (m_str) code = 3;
                end else begin
                    for (int i = NCHK - 1; i >= 0; i--) begin
                        if (m_valid[i] && m_addr[i] == dataadr) begin
                            any_addr = 1;
                            if (!m_matched[i]) begin
                                any_unm_addr = 1;
                                if (m_data[i] == writedata) hit = i;
                            end
                        end
                    end
                    if (hit < 0 && m_str) code = any_unm_addr ? 2 : (any_addr ? 0 : 1);
                end
            end
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (hit >= 0) m_matched[hit] = 1;
            all_done = 1;
            for (int i = 0; i < NCHK; i++) if (!m_matched[i]) all_done = 0;
            if (all_done) begin
                m_run = 0; m_done = 1; m_pass = 1;
            end else if (code != 0) begin
                m_run = 0; m_done = 1; m_fail = 1; m_code = code;
            end else if (pc > 32'(PC_LIMIT)) begin
                m_run = 0; m_done = 1; m_fail = 1; m_code = 4;
            end else if (m_cnt >= TIMEOUT) begin
                m_run = 0; m_done = 1; m_fail = 1; m_code = 5;
            end
        end
    endtask

    task automatic compare_model();
        check("done", 32'(done), 32'(m_done));
        check("pass", 32'(pass), 32'(m_pass));
        check("fail", 32'(fail), 32'(m_fail));
        check("fail_code", 32'(fail_code), 32'(m_code));
        check("match_mask", 32'(match_mask), 32'(m_maskv()));
        check("cycle_count", 32'(cycle_count), 32'(m_cnt));
    endtask

    task automatic tick();
        if (!reset) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic cfg(input logic [0:0] idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic go(input logic ord, input logic str);
        ordered = ord; strict = str; start = 1;
        tick();
        start = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        tick();
        memwrite = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0;
        start = 0; ordered = 0; strict = 0; memwrite = 0; dataadr = 0; writedata = 0; pc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", 32'(done), 0);
        check("reset_pass", 32'(pass), 0);
        check("reset_fail", 32'(fail), 0);
        check("reset_mask", 32'(match_mask), 0);
        check("reset_count", 32'(cycle_count), 0);
        reset = 1;

        // Unordered, non-strict: both expected writes complete the run.
        cfg(1'b0, 32'd1, 32'h0C0C000A);
        cfg(1'b1, 32'd63, 32'd0);
        go(1'b0, 1'b0);
        wr(32'd1, 32'h0C0C000A);
        check("t1_mid_mask", 32'(match_mask), 32'h1);
        wr(32'd63, 32'd0);
        check("t1_pass", 32'(pass), 1);
        check("t1_mask", 32'(match_mask), 32'h3);
        check("t1_code", 32'(fail_code), 0);

        // Ordered, strict: entry 1 arriving first is an order violation.
        go(1'b1, 1'b1);
        wr(32'd63, 32'd0);
        check("t2_fail", 32'(fail), 1);
        check("t2_code", 32'(fail_code), 3);
        check("t2_mask", 32'(match_mask), 0);

        // Stray write: fails when strict, ignored otherwise.
        go(1'b0, 1'b1);
        wr(32'd60, 32'd28);
        check("t3_code", 32'(fail_code), 1);
        go(1'b0, 1'b0);
        wr(32'd60, 32'd28);
        check("t3_ignored_fail", 32'(fail), 0);
        check("t3_ignored_done", 32'(done), 0);
        wr(32'd1, 32'h0C0C000A);
        wr(32'd63, 32'd0);
        check("t3_pass", 32'(pass), 1);

        // Data mismatch on an expected address.
        go(1'b0, 1'b1);
        wr(32'd1, 32'h12345678);
        check("t4_code", 32'(fail_code), 2);

        // PC runaway: pc=100 is still legal, pc=104 fails.
        go(1'b0, 1'b0);
        for (int k = 0; k <= 26; k++) begin
            pc = 32'(4 * k);
            tick();
            if (k == 25) check("t5_pc100_fail", 32'(fail), 0);
        end
        check("t5_code", 32'(fail_code), 4);
        check("t5_fail", 32'(fail), 1);

        // Timeout on the short-timeout instance with pc held at 0.
        pc = 0;
        go(1'b0, 1'b0);
        for (int k = 1; k <= TIMEOUT_T; k++) begin
            tick();
            if (k == TIMEOUT_T - 1) check("t6_before_fail", 32'(fail_t), 0);
        end
        check("t6_code", 32'(fail_code_t), 5);
        check("t6_count", 32'(cycle_count_t), 8);
        check("t6_done", 32'(done_t), 1);

        // Asynchronous reset in the middle of a run.
        reset = 0;
        #1;
        check("t7_done", 32'(done), 0);
        check("t7_pass", 32'(pass), 0);
        check("t7_fail", 32'(fail), 0);
        check("t7_code", 32'(fail_code), 0);
        check("t7_mask", 32'(match_mask), 0);
        check("t7_count", 32'(cycle_count), 0);
        check("t7_code_t", 32'(fail_code_t), 0);
        model_reset();
        tick();
        #2;
        reset = 1;

        // Empty table passes one cycle after entering RUN.
        go(1'b0, 1'b0);
        check("t8_running", 32'(done), 0);
        tick();
        check("t8_pass", 32'(pass), 1);
        check("t8_mask", 32'(match_mask), 32'h3);
        check("t8_count", 32'(cycle_count), 1);

        // cfg_we during RUN must not alter the table.
        cfg(1'b0, 32'd5, 32'h55);
        go(1'b0, 1'b1);
        cfg(1'b0, 32'd7, 32'h77);
        wr(32'd7, 32'h77);
        check("t9_code", 32'(fail_code), 1);

        // start and cfg_we together: the new entry joins the run.
        cfg_we = 1; cfg_idx = 1'b1; cfg_addr = 32'd9; cfg_data = 32'h99;
        go(1'b1, 1'b1);
        cfg_we = 0;
        wr(32'd5, 32'h55);
        check("t10_mask", 32'(match_mask), 32'h1);
        wr(32'd9, 32'h99);
        check("t10_pass", 32'(pass), 1);

        // Random traffic over a small address/data space against the model.
        for (int n = 0; n < 600; n++) begin
            int j;
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_idx   = 1'($urandom_range(0, NCHK - 1));
            cfg_addr  = 32'($urandom_range(0, 3));
            cfg_data  = 32'($urandom_range(0, 3));
            start     = ($urandom_range(0, 7) == 0);
            ordered   = 1'($urandom_range(0, 1));
            strict    = 1'($urandom_range(0, 1));
            memwrite  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(0, NCHK - 1));
                dataadr   = m_addr[j];
                writedata = m_data[j];
            end else begin
                dataadr   = 32'($urandom_range(0, 3));
                writedata = 32'($urandom_range(0, 3));
            end
            pc = ($urandom_range(0, 39) == 0) ? 32'(101 + $urandom_range(0, 3))
                                              : 32'($urandom_range(0, 100));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
